cordic_angle_sequencer: RTL

- Iteration controller for the floating-point CORDIC datapath. It sits directly upstream of the arctangent LUT: it drives the LUT address and registers the returned atan(2^-i) constant.
- It issues one micro-rotation per iteration to the external x/y/z FP add/sub units, using a start/ack handshake.
- It selects the add/sub direction of each unit from the sign of z, and signals completion after ITER iterations.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_iter_counter.sv | 42 ++++
 rtl/cordic_angle_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC iteration controller.
package cordic_pkg;

    localparam int W_DEF    = 32;
    localparam int N_DEF    = 4;
    localparam int ITER_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Direction bits ordered {sub_x, sub_y, sub_z}
    localparam logic [2:0] DIR_POS = 3'b101;
    localparam logic [2:0] DIR_NEG = 3'b010;

    function automatic logic [2:0] dir_bits(input logic z_neg);
        return z_neg ? DIR_NEG : DIR_POS;
    endfunction

endpackage

// File: rtl/cordic_iter_counter.sv
// Iteration index register: clear-to-zero, saturating increment,
// and a flag for the final iteration.
module cordic_iter_counter
    import cordic_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         zero,
    input  logic         inc,
    output logic [N-1:0] idx,
    output logic         last
);

    localparam logic [N-1:0] LAST_IDX = N'(ITER - 1);

    logic [N-1:0] idx_d;
    logic [N-1:0] idx_q;

    always_comb begin
        idx_d = idx_q;
        if (zero) begin
            idx_d = '0;
        end else if (inc && !last) begin
            idx_d = idx_q + N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Drives the atan LUT, latches rotation directions from z and
// launches one add/sub micro-rotation per iteration.
module cordic_angle_sequencer
    import cordic_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int N    = N_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         beg,
    input  logic         clr,
    input  logic         z_sign,
    input  logic         iter_ack,
    input  logic [W-1:0] lut_data,
    output logic [N-1:0] lut_addr,
    output logic [W-1:0] atan_q,
    output logic [N-1:0] shift_amt,
    output logic         sub_x,
    output logic         sub_y,
    output logic         sub_z,
    output logic         iter_start,
    output logic         busy,
    output logic         done
);

    state_e       state_d, state_q;
    logic [W-1:0] atan_d;
    logic [N-1:0] shift_d, shift_q;
    logic [2:0]   dir_d, dir_q;
    logic         start_d, start_q;
    logic         busy_d, busy_q;
    logic         done_d, done_q;
    logic         cnt_zero, cnt_inc;
    logic [N-1:0] idx;
    logic         last;

    cordic_iter_counter #(
        .N    (N),
        .ITER (ITER)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .zero (cnt_zero),
        .inc  (cnt_inc),
        .idx  (idx),
        .last (last)
    );

    always_comb begin
        state_d  = state_q;
        atan_d   = atan_q;
        shift_d  = shift_q;
        dir_d    = dir_q;
        cnt_zero = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (beg) begin
                    cnt_zero = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                atan_d  = lut_data;
                shift_d = idx;
                dir_d   = dir_bits(z_sign);
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (iter_ack) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort freezes the datapath registers and drops back to idle
        if (clr) begin
            state_d  = S_IDLE;
            atan_d   = atan_q;
            shift_d  = shift_q;
            dir_d    = dir_q;
            cnt_zero = 1'b0;
            cnt_inc  = 1'b0;
        end
        start_d = (state_d == S_ISSUE);
        busy_d  = state_d inside {S_LOAD, S_ISSUE, S_WAIT, S_NEXT};
        done_d  = (state_q == S_DONE) && !clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            atan_q  <= '0;
            shift_q <= '0;
            dir_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            atan_q  <= atan_d;
            shift_q <= shift_d;
            dir_q   <= dir_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign lut_addr   = idx;
    assign shift_amt  = shift_q;
    assign sub_x      = dir_q[2];
    assign sub_y      = dir_q[1];
    assign sub_z      = dir_q[0];
    assign iter_start = start_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
